// File: rtl/vga_pkg.sv
// Shared VGA raster constants, receiver state encoding and counter helpers.
package vga_pkg;

    localparam int H_TOTAL     = 800;
    localparam int H_START     = 144;
    localparam int H_ACTIVE    = 640;
    localparam int V_TOTAL     = 525;
    localparam int V_START     = 35;
    localparam int V_ACTIVE    = 480;
    localparam int LOCK_FRAMES = 2;
    localparam int RGB_W       = 12;
    localparam int CNT_W       = 10;
    localparam int LCK_W       = 4;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    // Raster counters stick at all-ones so a dead sync never wraps into the window.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Stage 1: sample sync/colour once per pixel tick and flag falling sync edges.
module vga_sync_edge
    import vga_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             pix_tick,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [RGB_W-1:0] s_rgb,
    output logic             hs_fall,
    output logic             vs_fall
);

    logic s_hs, s_vs, prev_hs, prev_vs;

    // Syncs idle high out of reset so the first sample cannot fake an edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s_hs    <= 1'b1;
            s_vs    <= 1'b1;
            prev_hs <= 1'b1;
            prev_vs <= 1'b1;
            s_rgb   <= '0;
        end else if (pix_tick) begin
            prev_hs <= s_hs;
            prev_vs <= s_vs;
            s_hs    <= h_sync;
            s_vs    <= v_sync;
            s_rgb   <= rgb_in;
        end
    end

    assign hs_fall = prev_hs & ~s_hs;
    assign vs_fall = prev_vs & ~s_vs;

endmodule

// File: rtl/vga_frame_receiver.sv
// Rebuilds raster coordinates from sync edges, locks to the timing and
// emits captured active pixels one pix_tick after they were presented.
module vga_frame_receiver
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int H_START     = vga_pkg::H_START,
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int V_START     = vga_pkg::V_START,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int LOCK_FRAMES = vga_pkg::LOCK_FRAMES
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             pix_tick,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] rx_x,
    output logic [CNT_W-1:0] rx_y,
    output logic [RGB_W-1:0] rx_rgb,
    output logic             rx_valid,
    output logic             frame_start,
    output logic             line_end,
    output logic             locked,
    output logic             err_sticky
);

    logic [RGB_W-1:0] s_rgb;
    logic             hs_fall, vs_fall;

    rx_state_t        state, state_nxt;
    logic [LCK_W-1:0] lock_cnt, lock_nxt;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt, cap_x, cap_y;
    logic             vs_pending, v_rst, h_err, v_err, err_set, in_win, capture;

    vga_sync_edge u_edge (
        .CLK      (CLK),
        .RESET    (RESET),
        .pix_tick (pix_tick),
        .h_sync   (h_sync),
        .v_sync   (v_sync),
        .rgb_in   (rgb_in),
        .s_rgb    (s_rgb),
        .hs_fall  (hs_fall),
        .vs_fall  (vs_fall)
    );

    // A pending vsync takes effect on the line start that follows it (or the same one).
    assign v_rst   = hs_fall & (vs_pending | vs_fall);
    assign h_nxt   = hs_fall ? '0 : sat_inc(h_cnt);
    assign v_nxt   = v_rst ? '0 : (hs_fall ? sat_inc(v_cnt) : v_cnt);
    assign h_err   = hs_fall & (h_cnt != CNT_W'(H_TOTAL - 1));
    assign v_err   = v_rst & (v_cnt != CNT_W'(V_TOTAL - 1));
    assign in_win  = (h_nxt >= CNT_W'(H_START)) && (h_nxt < CNT_W'(H_START + H_ACTIVE)) &&
                     (v_nxt >= CNT_W'(V_START)) && (v_nxt < CNT_W'(V_START + V_ACTIVE));
    // Gate on the next state so a lock loss kills capture on the very tick it happens.
    assign capture = (state_nxt == LOCKED) && in_win;
    assign cap_x   = h_nxt - CNT_W'(H_START);
    assign cap_y   = v_nxt - CNT_W'(V_START);

    // Lock FSM: errors only matter once the receiver has started acquiring.
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_cnt;
        err_set   = 1'b0;
        unique case (state)
            SEARCH: begin
                if (v_rst) begin
                    state_nxt = ACQUIRE;
                    lock_nxt  = '0;
                end
            end
            ACQUIRE: begin
                if (h_err || v_err) begin
                    state_nxt = SEARCH;
                    err_set   = 1'b1;
                end else if (v_rst) begin
                    lock_nxt = lock_cnt + 1'b1;
                    if (lock_cnt + 1'b1 >= LCK_W'(LOCK_FRAMES)) state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (h_err || v_err) begin
                    state_nxt = SEARCH;
                    err_set   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Stage 2 raster counters and FSM state, advanced once per pixel tick.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= SEARCH;
            lock_cnt   <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            vs_pending <= 1'b0;
        end else if (pix_tick) begin
            state      <= state_nxt;
            lock_cnt   <= lock_nxt;
            h_cnt      <= h_nxt;
            v_cnt      <= v_nxt;
            vs_pending <= v_rst ? 1'b0 : (vs_pending | vs_fall);
        end
    end

    // Pixel output: strobes last one CLK, captured fields hold outside the window.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_x        <= '0;
            rx_y        <= '0;
            rx_rgb      <= '0;
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            if (pix_tick) begin
                locked <= (state_nxt == LOCKED);
                if (capture) begin
                    rx_valid    <= 1'b1;
                    rx_x        <= cap_x;
                    rx_y        <= cap_y;
                    rx_rgb      <= s_rgb;
                    frame_start <= (cap_x == '0) && (cap_y == '0);
                    line_end    <= (cap_x == CNT_W'(H_ACTIVE - 1));
                end
            end
        end
    end

    // Sticky timing error; a fresh error beats a simultaneous clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                 err_sticky <= 1'b0;
        else if (pix_tick && err_set) err_sticky <= 1'b1;
        else if (err_clr)           err_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Directed bench for vga_frame_receiver on a shrunken raster:
// 20 periods/line (sync 3, active 6..15), 12 lines/frame (vsync 2, active 3..8).
module tb_vga_frame_receiver;

    localparam int HT = 20, HS = 3, HST = 6, HA = 10;
    localparam int VT = 12, VS = 2, VST = 3, VA = 6;

    logic        CLK = 1'b0;
    logic        RESET, pix_tick, h_sync, v_sync, err_clr;
    logic [11:0] rgb_in, rx_rgb;
    logic [9:0]  rx_x, rx_y;
    logic        rx_valid, frame_start, line_end, locked, err_sticky;

    int n_chk = 0;
    int n_err = 0;
    int nvalid = 0;
    int n0;

    logic       p_act;
    logic [9:0] p_x, p_y;

    vga_frame_receiver #(
        .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .CLK(CLK), .RESET(RESET), .pix_tick(pix_tick), .h_sync(h_sync), .v_sync(v_sync),
        .rgb_in(rgb_in), .err_clr(err_clr), .rx_x(rx_x), .rx_y(rx_y), .rx_rgb(rx_rgb),
        .rx_valid(rx_valid), .frame_start(frame_start), .line_end(line_end),
        .locked(locked), .err_sticky(err_sticky)
    );

    always #5 CLK = ~CLK;

    // Count every rx_valid strobe (each is high across exactly one falling edge).
    always @(negedge CLK) if (rx_valid) nvalid <= nvalid + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one pixel period; on its tick edge the previous pixel must come out.
    task automatic px(input int hp, input int vp, input logic hs, input logic vs,
                      input logic exp_v, input logic clr);
        logic       act, was;
        logic [9:0] x, y;
        act = (hp >= HST) && (hp < HST + HA) && (vp >= VST) && (vp < VST + VA);
        x   = 10'(hp - HST);
        y   = 10'(vp - VST);
        @(negedge CLK);
        h_sync = hs; v_sync = vs; err_clr = clr; pix_tick = 1'b1;
        rgb_in = act ? {x[3:0], y[3:0], 4'h5} : 12'h000;
        @(posedge CLK); #1;
        was = p_act;
        if (p_act) begin
            chk("valid", 32'(rx_valid), 32'd1);
            chk("x", 32'(rx_x), 32'(p_x));
            chk("y", 32'(rx_y), 32'(p_y));
            chk("rgb", 32'(rx_rgb), 32'({p_x[3:0], p_y[3:0], 4'h5}));
            chk("frame_start", 32'(frame_start), 32'((p_x == 0) && (p_y == 0)));
            chk("line_end", 32'(line_end), 32'(p_x == 10'(HA - 1)));
        end
        p_act = act && exp_v;
        p_x = x; p_y = y;
        @(negedge CLK);
        pix_tick = 1'b0; err_clr = 1'b0;
        @(posedge CLK); #1;
        if (was) chk("valid_1clk", 32'(rx_valid), 32'd0);
    endtask

    // Lines v0..v1-1; line sl is one period short; lines below vu expect capture;
    // err_clr is raised on the second tick of line cl.
    task automatic send_frame(input int v0, input int v1, input int sl, input int vu, input int cl);
        for (int vp = v0; vp < v1; vp++)
            for (int hp = 0; hp < ((vp == sl) ? HT - 1 : HT); hp++)
                px(hp, vp, hp >= HS, vp >= VS, vp < vu, (vp == cl) && (hp == 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; pix_tick = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
        rgb_in = '0; err_clr = 1'b0; p_act = 1'b0; p_x = '0; p_y = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_x", 32'(rx_x), 0);
        chk("rst_y", 32'(rx_y), 0);
        chk("rst_rgb", 32'(rx_rgb), 0);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_le", 32'(line_end), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err_sticky), 0);
        @(negedge CLK) RESET = 1'b1;

        // Initial lock: third frame start locks.
        n0 = nvalid;
        send_frame(0, VT, -1, 0, -1);
        chk("acq_f1_locked", 32'(locked), 0);
        send_frame(0, VT, -1, 0, -1);
        chk("acq_f2_locked", 32'(locked), 0);
        chk("acq_no_valid", 32'(nvalid - n0), 0);
        n0 = nvalid;
        send_frame(0, VT, -1, VT, -1);
        chk("lock_f3", 32'(locked), 1);
        chk("f3_count", 32'(nvalid - n0), HA * VA);
        chk("f3_err", 32'(err_sticky), 0);
        send_frame(0, VT, -1, VT, -1);

        // Short line at vp=5 with err_clr on the error tick.
        n0 = nvalid;
        send_frame(0, VT, 5, 6, 6);
        chk("hlost_locked", 32'(locked), 0);
        chk("err_wins", 32'(err_sticky), 1);
        chk("hlost_count", 32'(nvalid - n0), 3 * HA);
        @(negedge CLK) err_clr = 1'b1;
        @(posedge CLK); #1;
        chk("err_clr", 32'(err_sticky), 0);
        @(negedge CLK) err_clr = 1'b0;

        n0 = nvalid;
        send_frame(0, VT, -1, 0, -1);
        send_frame(0, VT, -1, 0, -1);
        chk("hrelock_pending", 32'(locked), 0);
        send_frame(0, VT, -1, VT, -1);
        chk("hrelock", 32'(locked), 1);
        chk("hrelock_count", 32'(nvalid - n0), HA * VA);

        // Frame one line short: v_err at next frame start.
        n0 = nvalid;
        send_frame(0, VT - 1, -1, VT, -1);
        chk("short_frame_count", 32'(nvalid - n0), HA * VA);
        send_frame(0, VT, -1, 0, -1);
        chk("verr_locked", 32'(locked), 0);
        chk("verr_sticky", 32'(err_sticky), 1);
        send_frame(0, VT, -1, 0, -1);
        send_frame(0, VT, -1, 0, -1);
        chk("vrelock_pending", 32'(locked), 0);
        send_frame(0, VT, -1, VT, -1);
        chk("vrelock", 32'(locked), 1);
        chk("vrelock_count", 32'(nvalid - n0), 2 * HA * VA);

        // Reset, then hsync stuck high while vsync toggles.
        @(negedge CLK) RESET = 1'b0;
        p_act = 1'b0;
        @(negedge CLK) RESET = 1'b1;
        n0 = nvalid;
        for (int i = 0; i < 1100; i++) px(0, 0, 1'b1, ((i / 20) % 2) != 0, 1'b0, 1'b0);
        chk("nohs_locked", 32'(locked), 0);
        chk("nohs_count", 32'(nvalid - n0), 0);
        chk("nohs_err", 32'(err_sticky), 0);

        // Lock again, then reset mid-line.
        send_frame(0, VT, -1, 0, -1);
        send_frame(0, VT, -1, 0, -1);
        send_frame(0, VT, -1, VT, -1);
        chk("lock2", 32'(locked), 1);
        send_frame(0, 5, -1, 5, -1);
        for (int hp = 0; hp < 10; hp++) px(hp, 5, hp >= HS, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_x", 32'(rx_x), 2);
        @(negedge CLK); #2;
        RESET = 1'b0;
        p_act = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 0);
        chk("arst_x", 32'(rx_x), 0);
        chk("arst_y", 32'(rx_y), 0);
        chk("arst_rgb", 32'(rx_rgb), 0);
        chk("arst_valid", 32'(rx_valid), 0);
        @(negedge CLK) RESET = 1'b1;
        n0 = nvalid;
        for (int hp = 10; hp < HT; hp++) px(hp, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(6, VT, -1, 0, -1);
        send_frame(0, VT, -1, 0, -1);
        send_frame(0, VT, -1, 0, -1);
        chk("rst_relock_none", 32'(nvalid - n0), 0);
        chk("rst_relock_pending", 32'(locked), 0);
        send_frame(0, VT, -1, VT, -1);
        chk("rst_relock", 32'(locked), 1);
        chk("rst_relock_count", 32'(nvalid - n0), HA * VA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
